// File: rtl/cdc_sched_pkg.sv
// Shared types and width helpers for the CDC handshake scheduler and its arbiter.
package cdc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Index width that never collapses to zero bits for tiny vectors.
  function automatic int clog2_min1(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or after ptr.
module rr_arbiter
  import cdc_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]               req,
  input  logic [clog2_min1(N)-1:0]   ptr,
  input  logic                       en,
  output logic [N-1:0]               grant,
  output logic [clog2_min1(N)-1:0]   idx,
  output logic                       any
);

  localparam int IW = clog2_min1(N);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [IW-1:0] cand_s;
  logic          hit_s;
  int unsigned   pos_s;

  // Walk the ring from ptr; the first hit latches and masks later candidates.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    pos_s  = 32'd0;
    for (int i = 0; i < N; i++) begin
      pos_s  = 32'(ptr) + 32'(i);
      pos_s  = (pos_s >= 32'(N)) ? (pos_s - 32'(N)) : pos_s;
      cand_s = IW'(pos_s);
      hit_s  = en & ~any & req[cand_s];
      grant  = grant | (hit_s ? (ONE_HOT0 << cand_s) : '0);
      idx    = hit_s ? cand_s : idx;
      any    = any | hit_s;
    end
  end

endmodule

// File: rtl/cdc_handshake_sched.sv
// Source-domain scheduler for one four-phase req/ack channel: round-robin grant,
// payload capture, handshake sequencing against the synchronized ack, timeout abort.
module cdc_handshake_sched
  import cdc_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [N_REQ-1:0]               i_req,
  input  logic [N_REQ*DATA_W-1:0]        i_data,
  output logic [N_REQ-1:0]               o_grant,
  output logic                           o_xfer_req,
  output logic [DATA_W-1:0]              o_xfer_data,
  output logic [clog2_min1(N_REQ)-1:0]   o_xfer_id,
  input  logic                           i_xfer_ack,
  output logic                           o_done,
  output logic                           o_err,
  output logic                           o_busy
);

  localparam int IDW = clog2_min1(N_REQ);
  localparam int CW  = clog2_min1(TIMEOUT);

  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);
  localparam logic [IDW-1:0] ID_ONE   = IDW'(32'd1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                xreq_q, xreq_d;
  logic [DATA_W-1:0]   xdata_q, xdata_d;
  logic [IDW-1:0]      xid_q, xid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                arb_en_s;
  logic [N_REQ-1:0]    arb_grant_s;
  logic [IDW-1:0]      arb_idx_s;
  logic                arb_any_s;
  logic [CW-1:0]       cnt_inc_s;

  // A stale-high ack in IDLE means the far side has not finished; hold off new grants.
  assign arb_en_s  = (state_q == IDLE) && !i_xfer_ack;
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req   (i_req),
    .ptr   (ptr_q),
    .en    (arb_en_s),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .any   (arb_any_s)
  );

  // Next-state and next-output logic; an ack edge always beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    xreq_d  = xreq_q;
    xdata_d = xdata_q;
    xid_d   = xid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (arb_any_s) begin
          state_d = REQ;
          grant_d = arb_grant_s;
          xreq_d  = 1'b1;
          xdata_d = i_data[int'(arb_idx_s)*DATA_W +: DATA_W];
          xid_d   = arb_idx_s;
          ptr_d   = (arb_idx_s == ID_LAST) ? '0 : (arb_idx_s + ID_ONE);
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (i_xfer_ack) begin
          state_d = ACK_LOW;
          xreq_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
          xreq_d  = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ACK_LOW: begin
        if (!i_xfer_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      DRAIN: begin
        cnt_d = '0;
        if (!i_xfer_ack) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        xreq_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      xreq_q  <= 1'b0;
      xdata_q <= '0;
      xid_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      xreq_q  <= xreq_d;
      xdata_q <= xdata_d;
      xid_q   <= xid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_xfer_req  = xreq_q;
  assign o_xfer_data = xdata_q;
  assign o_xfer_id   = xid_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;

endmodule
